// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU, VPU) and the memory.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // CPU load/store path
    logic              cpu_re;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // VPU memory port
    logic              vpu_req;
    logic              vpu_we;
    logic [ADDR_W-1:0] vpu_addr;
    logic [DATA_W-1:0] vpu_wdata;
    logic              vpu_gnt;
    logic              vpu_rvalid;
    logic [DATA_W-1:0] vpu_rdata;

    // Single-ported memory
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  vpu_req, vpu_we, vpu_addr, vpu_wdata,
        output vpu_gnt, vpu_rvalid, vpu_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output vpu_req, vpu_we, vpu_addr, vpu_wdata,
        input  vpu_gnt, vpu_rvalid, vpu_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter sharing one pipelined data memory with the VPU; read data is routed back
// through an owner-tag pipeline. Define DMEM_ARB_STARVE_EN to add the VPU anti-starvation counter.
module dmem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        C_IDLE,
        C_RD_WAIT,
        C_RD_DONE
    } cpu_state_t;

    cpu_state_t         cpu_state_reg;
    logic [LAT_W-1:0]   lat_cnt_reg;
    logic [MEM_LAT-1:0] tag_valid_reg;
    logic [MEM_LAT-1:0] tag_vpu_reg;
    logic [MEM_LAT-1:0] tag_valid_next;
    logic [MEM_LAT-1:0] tag_vpu_next;
    logic [DATA_W-1:0]  cpu_rdata_reg;
    logic [DATA_W-1:0]  vpu_rdata_reg;
    logic               vpu_rvalid_reg;

    logic              cpu_req;
    logic              cpu_gnt;
    logic              vpu_gnt;
    logic              starve_force;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    assign cpu_req = bus.cpu_re | bus.cpu_we;

`ifdef DMEM_ARB_STARVE_EN
    // Saturating count of cycles the VPU has waited; at the limit it beats an idle-state CPU.
    logic [7:0] starve_cnt_reg;

    assign starve_force = bus.vpu_req && (starve_cnt_reg >= 8'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (vpu_gnt) begin
            starve_cnt_reg <= '0;
        end else if (bus.vpu_req && (starve_cnt_reg != 8'hFF)) begin
            starve_cnt_reg <= starve_cnt_reg + 8'd1;
        end
    end
`else
    logic [7:0] unused_starve_max;

    assign unused_starve_max = 8'(STARVE_MAX);
    assign starve_force      = 1'b0;
`endif

    // The CPU only competes from C_IDLE, so a held cpu_re is not re-granted in C_RD_DONE.
    assign cpu_gnt = (cpu_state_reg == C_IDLE) && cpu_req && !starve_force;
    assign vpu_gnt = bus.vpu_req && !cpu_gnt;

    // A simultaneous cpu_re/cpu_we resolves as a store.
    assign mem_we    = cpu_gnt ? bus.cpu_we  : (vpu_gnt & bus.vpu_we);
    assign mem_re    = cpu_gnt ? !bus.cpu_we : (vpu_gnt & !bus.vpu_we);
    assign addr_mux  = cpu_gnt ? bus.cpu_addr  : bus.vpu_addr;
    assign wdata_mux = cpu_gnt ? bus.cpu_wdata : bus.vpu_wdata;

    assign bus.mem_we    = mem_we;
    assign bus.mem_re    = mem_re;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.vpu_gnt   = vpu_gnt;

    assign bus.cpu_stall = (cpu_state_reg == C_RD_WAIT) ||
                           ((cpu_state_reg == C_IDLE) && cpu_req && !(cpu_gnt && bus.cpu_we));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_state_reg <= C_IDLE;
            lat_cnt_reg   <= '0;
        end else begin
            case (cpu_state_reg)
                C_IDLE: begin
                    if (cpu_gnt && !bus.cpu_we) begin
                        cpu_state_reg <= C_RD_WAIT;
                        lat_cnt_reg   <= '0;
                    end
                end
                C_RD_WAIT: begin
                    if (lat_cnt_reg == LAT_W'(MEM_LAT - 1)) begin
                        cpu_state_reg <= C_RD_DONE;
                        lat_cnt_reg   <= '0;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
                    end
                end
                C_RD_DONE: cpu_state_reg <= C_IDLE;
                default:   cpu_state_reg <= C_IDLE;
            endcase
        end
    end

    // Owner tags travel alongside the memory pipeline so the last stage lines up with mem_rdata.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_next[gi] = mem_re;
                assign tag_vpu_next[gi]   = vpu_gnt;
            end else begin : g_tail
                assign tag_valid_next[gi] = tag_valid_reg[gi-1];
                assign tag_vpu_next[gi]   = tag_vpu_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_reg <= '0;
            tag_vpu_reg   <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_vpu_reg   <= tag_vpu_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_reg  <= '0;
            vpu_rdata_reg  <= '0;
            vpu_rvalid_reg <= 1'b0;
        end else begin
            vpu_rvalid_reg <= tag_valid_reg[MEM_LAT-1] & tag_vpu_reg[MEM_LAT-1];
            if (tag_valid_reg[MEM_LAT-1]) begin
                if (tag_vpu_reg[MEM_LAT-1]) begin
                    vpu_rdata_reg <= bus.mem_rdata;
                end else begin
                    cpu_rdata_reg <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.cpu_rdata  = cpu_rdata_reg;
    assign bus.vpu_rdata  = vpu_rdata_reg;
    assign bus.vpu_rvalid = vpu_rvalid_reg;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory between the CPU load/store path and the VPU memory port. The CPU has priority; an optional anti-starvation counter guarantees the VPU forward progress. Read data returns through a latency-matched owner-tag pipeline. The block stalls the CPU through `cpu_stall`, which the CPU ORs into its stall logic alongside `STALL_control`.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LAT`, 1, memory read latency in cycles (≥1); `mem_rdata` is valid `MEM_LAT` cycles after `mem_re`
- `STARVE_MAX`, 4, VPU wait cycles before a forced VPU grant (1..255)

- `clk` in 1: system clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cpu_re` in 1: CPU load request; held until `cpu_stall` falls
- `cpu_we` in 1: CPU store request; held until `cpu_stall` falls
- `cpu_addr` in ADDR_W: CPU address
- `cpu_wdata` in DATA_W: CPU store data
- `cpu_rdata` out DATA_W: CPU load data (registered)
- `cpu_stall` out 1: CPU must hold its state (combinational)
- `vpu_req` in 1: VPU access request; held until `vpu_gnt`
- `vpu_we` in 1: 1 = store, 0 = load
- `vpu_addr` in ADDR_W: VPU address
- `vpu_wdata` in DATA_W: VPU store data
- `vpu_gnt` out 1: VPU request accepted this cycle (combinational)
- `vpu_rvalid` out 1: one-cycle pulse; `vpu_rdata` valid (registered)
- `vpu_rdata` out DATA_W: VPU load data (registered)
- `mem_re`, `mem_we` out 1: memory strobes (combinational)
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: memory address and data (combinational mux)
- `mem_rdata` in DATA_W: memory read data

## Operation
- **CPU FSM states:** `C_IDLE`, `C_RD_WAIT`, `C_RD_DONE`.
- **C_IDLE:** CPU requests when `cpu_re | cpu_we`. If both are high, the store wins.
  - Granted store: completes that cycle; `cpu_stall` is 0 that cycle.
  - Granted load: FSM goes to `C_RD_WAIT`.
- **C_RD_WAIT:** counts `MEM_LAT` cycles. The CPU is excluded from arbitration. On the last count, `mem_rdata` is captured into `cpu_rdata` and the FSM goes to `C_RD_DONE`.
- **C_RD_DONE:** lasts one cycle. `cpu_stall` is 0 and the CPU is excluded from arbitration, so the held `cpu_re` is not re-granted. The FSM returns to `C_IDLE`.
- **`cpu_stall`:**
  - 1 in `C_RD_WAIT`.
  - 1 in `C_IDLE` when the CPU requests and is not granted, or is granted a load.
  - 0 otherwise.
- **Arbitration (per cycle):** the CPU wins if it requests in `C_IDLE`, unless the starve override is active. Otherwise the VPU wins if `vpu_req` is high. Exactly one access is issued per cycle.
- **VPU loads:** may issue while a CPU load is in flight; the memory is pipelined.
- **Owner-tag pipeline:** `MEM_LAT` stages of {valid, owner}, pushed on every `mem_re`.
  - At the stage output, VPU-owned data is registered into `vpu_rdata` and `vpu_rvalid` pulses.
  - CPU-owned data is captured into `cpu_rdata`.
- **Arithmetic:**
  - Starve counter: 8 bits, saturating.
  - Latency counter: `$clog2(MEM_LAT+1)` bits.

## Timing
- **CPU store** granted at cycle t: `mem_we` is driven at t; `cpu_stall` is 0 at t.
- **CPU load** granted at t:
  - `mem_re` at t; `cpu_stall` is 1 for cycles t..t+MEM_LAT.
  - `cpu_rdata` is valid and `cpu_stall` is 0 at t+MEM_LAT+1 (the `C_RD_DONE` cycle).
- **VPU load** granted at t: `vpu_rvalid` pulses at t+MEM_LAT+1.
- **VPU store** granted at t: `mem_we` at t.
- **Reset values:**
  - FSM `C_IDLE`; tags, counters, `cpu_rdata`, `vpu_rdata` and `vpu_rvalid` all 0.
  - Combinational outputs follow the rules above from reset state.
- **Reset mid-operation:** in-flight tags are cleared. Late `mem_rdata` is ignored and no `vpu_rvalid` is produced.

## Configuration
- **`DMEM_ARB_STARVE_EN` defined:**
  - The starve counter increments each cycle `vpu_req` is high without `vpu_gnt`, and clears on `vpu_gnt`.
  - When count ≥ `STARVE_MAX`, the VPU wins the next cycle it requests, even if the CPU requests in `C_IDLE`. The CPU stays stalled that cycle.
- **Undefined:** strict CPU priority. The counter logic is absent and the VPU can starve.

## Test plan
- **CPU store only:** `cpu_we=1`, `cpu_addr=0x0010`, `cpu_wdata=0xBEEF` → `mem_we=1`, `mem_addr=0x0010` the same cycle; `cpu_stall=0`.
- **CPU load, `MEM_LAT=2`:** memory returns 0x1234 → `cpu_stall` high for 3 cycles, then `cpu_rdata=0x1234` with `cpu_stall=0`; exactly one `mem_re` issued.
- **Collision:** CPU and VPU request the same cycle (macro off) → CPU granted, `vpu_gnt=0`. The VPU is granted the next cycle the CPU is not requesting in `C_IDLE`.
- **Starvation, macro on, `STARVE_MAX=4`:** continuous CPU stores plus `vpu_req` → `vpu_gnt` on the 5th cycle; `cpu_stall=1` that cycle.
- **Interleave:** CPU load at t, VPU load at t+1, `MEM_LAT=1`, memory returns 0xAAAA then 0x5555 → `cpu_rdata=0xAAAA` at t+2; `vpu_rvalid` with `vpu_rdata=0x5555` at t+3.
- **Async reset:** drive `rst_n=0` mid-VPU-load → all registered outputs 0 immediately; no `vpu_rvalid` after release.
